// File: rtl/pic.sv
// ============================================================================
//  Module      : pic
//  Description : Priority interrupt controller. Latches per-source pulses,
//                masks them, and presents the lowest-index enabled source.
//                Define PIC_OVERRUN_EN to enable per-source lost-pulse flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ack,
  input  logic [NSRC-1:0] ovr_clr,
  output logic            irq,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] overrun
);

  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] w_active;
  logic [NSRC-1:0] w_ack_clr;
  logic [IDW-1:0]  w_id;
  logic            w_irq;
  logic            w_ack_ok;

  assign w_active = r_pending & r_mask;
  assign w_irq    = |w_active;
  assign w_ack_ok = clk_en & ack & w_irq;

  // Scan from the top so the lowest enabled index is the last one written.
  always_comb begin
    w_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_id = IDW'(i);
    end
  end

  // Isolate the lowest set bit of w_active: exactly the presented source.
  assign w_ack_clr = w_ack_ok ? (w_active & (~w_active + NSRC'(1))) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_clr) | irq_in;
      if (clk_en && mask_we) r_mask <= mask_wdata;
    end
  end

`ifdef PIC_OVERRUN_EN
  logic [NSRC-1:0] r_overrun;
  logic [NSRC-1:0] w_ovr_set;
  logic [NSRC-1:0] w_ovr_clr;

  // A pulse is lost only if the pending bit survives this edge.
  assign w_ovr_set = irq_in & r_pending & ~w_ack_clr;
  assign w_ovr_clr = clk_en ? ovr_clr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun & ~w_ovr_clr) | w_ovr_set;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = ^ovr_clr;
  assign overrun = '0;
`endif

  assign irq     = w_irq;
  assign irq_id  = w_id;
  assign pending = r_pending;
  assign mask    = r_mask;

endmodule

`default_nettype wire

// File: doc/pic.md
PIC -- requirements
Module: pic

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (2..32).
REQ-002 SHALL have parameter IDW, default 3, irq_id width, equal to ceil(log2(NSRC)).
REQ-003 SHALL have port clk, input, 1: base clock, the 100MHz domain, not gated by clk_en.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clk_en, input, 1: CPU clock enable; qualifies every CPU-side write and ack.
REQ-006 SHALL have port irq_in, input, NSRC: per-source one-cycle interrupt pulses; bit 0 is the interval timer.
REQ-007 SHALL have port mask_we, input, 1: mask register write strobe.
REQ-008 SHALL have port mask_wdata, input, NSRC: new mask value; 1 = source enabled.
REQ-009 SHALL have port ack, input, 1: CPU acknowledges the currently presented interrupt.
REQ-010 SHALL have port ovr_clr, input, NSRC: write-1-to-clear strobe for overrun bits.
REQ-011 SHALL have port irq, output, 1: interrupt request to the CPU, level.
REQ-012 SHALL have port irq_id, output, IDW: index of the presented source.
REQ-013 SHALL have port pending, output, NSRC: latched pending bits, CPU-readable.
REQ-014 SHALL have port mask, output, NSRC: current mask register.
REQ-015 SHALL have port overrun, output, NSRC: per-source lost-pulse flags.

Function
REQ-016 SHALL set pending[i] on any clk edge where irq_in[i]=1, independent of clk_en and mask.
REQ-017 SHALL drive irq = OR(pending AND mask), combinational from registers; a pulse sampled at edge N gives irq=1 immediately after edge N.
REQ-018 SHALL drive irq_id = lowest index i with pending[i] AND mask[i]; irq_id = 0 when irq = 0.
REQ-019 SHALL treat clk_en=1 AND ack=1 AND irq=1 at an edge as an accepted ack, clearing pending[irq_id] using pre-edge irq_id.
REQ-020 SHALL ignore ack when clk_en=0 or irq=0; no state change.
REQ-021 SHALL, on a new pulse on the acked source in the same cycle as the ack, leave pending set (set wins).
REQ-022 SHALL load mask <= mask_wdata on an edge with clk_en=1 and mask_we=1.
REQ-023 SHALL evaluate a simultaneous mask write and ack against the old mask.
REQ-024 SHALL not clear pending on mask write; a masked pending source reappears when it is unmasked.
REQ-025 SHALL never drop a pulse: pending is cleared only by an accepted ack or by reset.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force pending=0, mask=0, overrun=0, irq=0 and irq_id=0.
REQ-027 SHALL ignore irq_in pulses while rst_n=0.
REQ-028 SHALL resume normal operation on the first clk edge after rst_n deasserts; reset mid-ack discards the ack.

Configuration
REQ-029 SHALL, with PIC_OVERRUN_EN defined, set overrun[i] when irq_in[i]=1 while pending[i]=1 and pending[i] is not being cleared by an ack at that edge.
REQ-030 SHALL, with PIC_OVERRUN_EN defined, clear overrun[i] on an edge with clk_en=1 and ovr_clr[i]=1; a simultaneous set wins.
REQ-031 SHALL, without PIC_OVERRUN_EN, tie overrun to 0 and ignore ovr_clr; ports remain present.

Verification
REQ-032 SHALL cover: reset, mask=0x01, single pulse irq_in=0x01 -> irq=1, irq_id=0 next cycle; ack with clk_en=1 -> irq=0, pending=0x00.
REQ-033 SHALL cover: mask=0xFF, pulses on bits 5 and 2 in the same cycle -> irq_id=2; ack -> irq_id=5; second ack -> irq=0.
REQ-034 SHALL cover: mask=0x00, pulse on bit 3 -> pending=0x08, irq=0; write mask=0x08 -> irq=1, irq_id=3.
REQ-035 SHALL cover: ack held high with clk_en=0 for 10 cycles -> pending unchanged; single cycle with clk_en=1 -> one clear only.
REQ-036 SHALL cover: PIC_OVERRUN_EN, two pulses on bit 0 with no ack between -> overrun=0x01; pulse coincident with ack -> pending[0]=1, overrun unchanged; ovr_clr=0x01 with clk_en=1 -> overrun=0x00.
REQ-037 SHALL cover: rst_n low mid-sequence with pending=0xA5, mask=0xFF -> all outputs 0 without a clk edge; pulse during reset -> pending stays 0.
